// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/IO arbiter for one shared single-cycle memory port, 2-cycle access/response
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (forces an I/O grant after seven CPU grants while I/O waits)
module mem_arbiter (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        io_req,
    input  logic        io_we,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_wdata,
    output logic        io_ack,
    output logic [15:0] io_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  arb_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        RESP    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] lat_addr, lat_wdata;
    logic        lat_we;
    logic        owner_io;
    logic        any_req;
    logic        arb_open;
    logic        grant_io;

    assign any_req  = cpu_req | io_req;
    // RESP doubles as an arbitration slot so back-to-back accesses need no idle cycle
    assign arb_open = (state == IDLE) || (state == RESP);

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign grant_io = io_req & (~cpu_req | (starve_cnt == 3'd7));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            starve_cnt <= 3'd0;
        end else if (arb_open && any_req) begin
            if (grant_io || !io_req)
                starve_cnt <= 3'd0;
            else
                starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign grant_io = io_req & ~cpu_req;
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            lat_addr  <= 16'h0000;
            lat_wdata <= 16'h0000;
            lat_we    <= 1'b0;
            owner_io  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (arb_open && any_req) begin
                owner_io  <= grant_io;
                lat_we    <= grant_io ? io_we    : cpu_we;
                lat_addr  <= grant_io ? io_addr  : cpu_addr;
                lat_wdata <= grant_io ? io_wdata : cpu_wdata;
            end
        end
    end

    // Read data is captured at the ACCESS->RESP edge; the other requester's copy is untouched
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cpu_rdata <= 16'h0000;
            io_rdata  <= 16'h0000;
        end else if (state == ACCESS && !lat_we) begin
            if (owner_io)
                io_rdata  <= mem_rdata;
            else
                cpu_rdata <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        cpu_ack   = 1'b0;
        io_ack    = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = any_req ? ACCESS : IDLE;
            end
            ACCESS: begin
                state_nxt = RESP;
                mem_re    = ~lat_we;
                mem_we    = lat_we;
            end
            RESP: begin
                state_nxt = any_req ? ACCESS : IDLE;
                cpu_ack   = ~owner_io;
                io_ack    = owner_io;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign arb_state = state;
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
    logic        io_req = 1'b0, io_we = 1'b0;
    logic [15:0] io_addr = 16'h0, io_wdata = 16'h0;
    logic [15:0] mem_rdata = 16'h0;
    logic        cpu_ack, cpu_stall, io_ack, mem_re, mem_we;
    logic [15:0] cpu_rdata, io_rdata, mem_addr, mem_wdata;
    logic [1:0]  arb_state;

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .arb_state(arb_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a grant starts a 2-cycle transaction; m_left counts cycles still to run (2=access, 1=response)
    int          m_left;
    bit          m_own_io, m_we;
    logic [15:0] m_addr, m_wdata, m_cpu_rdata, m_io_rdata;
`ifdef MEM_ARB_STARVE_GUARD_EN
    int          m_starve;
`endif
    bit          cpu_busy, io_busy;

    task automatic model_reset();
        m_left = 0; m_own_io = 0; m_we = 0;
        m_addr = 16'h0; m_wdata = 16'h0; m_cpu_rdata = 16'h0; m_io_rdata = 16'h0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        m_starve = 0;
`endif
        cpu_busy = 0; io_busy = 0;
    endtask

    task automatic model_step();
        bit pick_io;
        if (m_left == 2) begin
            m_left = 1;
            if (!m_we) begin
                if (m_own_io) m_io_rdata = mem_rdata;
                else          m_cpu_rdata = mem_rdata;
            end
        end else begin
            m_left = 0;
            if (cpu_req || io_req) begin
                pick_io = io_req && !cpu_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
                if (io_req && m_starve >= 7) pick_io = 1;
                if (pick_io || !io_req) m_starve = 0;
                else                    m_starve = m_starve + 1;
`endif
                m_own_io = pick_io;
                m_we     = pick_io ? io_we : cpu_we;
                m_addr   = pick_io ? io_addr : cpu_addr;
                m_wdata  = pick_io ? io_wdata : cpu_wdata;
                m_left   = 2;
            end
        end
    endtask

    task automatic check_outputs();
        bit acc, rsp;
        acc = (m_left == 2);
        rsp = (m_left == 1);
        check_eq("arb_state", 16'(arb_state), acc ? 16'd1 : (rsp ? 16'd2 : 16'd0));
        check_eq("mem_re", 16'(mem_re), 16'(acc && !m_we));
        check_eq("mem_we", 16'(mem_we), 16'(acc && m_we));
        check_eq("mem_addr", mem_addr, m_addr);
        check_eq("mem_wdata", mem_wdata, m_wdata);
        check_eq("cpu_ack", 16'(cpu_ack), 16'(rsp && !m_own_io));
        check_eq("io_ack", 16'(io_ack), 16'(rsp && m_own_io));
        check_eq("cpu_rdata", cpu_rdata, m_cpu_rdata);
        check_eq("io_rdata", io_rdata, m_io_rdata);
        check_eq("cpu_stall", 16'(cpu_stall), 16'(cpu_req && !(rsp && !m_own_io)));
    endtask

    // Inputs are set at a falling edge; the model advances across the next rising edge
    task automatic run_cycle();
        model_step();
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic rand_drive();
        bit ack_c, ack_i, acc_c, acc_i;
        ack_c = (m_left == 1) && !m_own_io;
        ack_i = (m_left == 1) &&  m_own_io;
        acc_c = (m_left == 2) && !m_own_io;
        acc_i = (m_left == 2) &&  m_own_io;
        if (ack_c) cpu_busy = 0;
        if (ack_i) io_busy = 0;
        if (acc_c && $urandom_range(0, 3) == 0) begin
            cpu_req = 0; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        end else if (!cpu_busy) begin
            cpu_req = ($urandom_range(0, 2) != 0);
            cpu_busy = cpu_req;
            cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        end
        if (acc_i && $urandom_range(0, 3) == 0) begin
            io_req = 0; io_we = 1'($urandom); io_addr = 16'($urandom); io_wdata = 16'($urandom);
        end else if (!io_busy) begin
            io_req = ($urandom_range(0, 1) != 0);
            io_busy = io_req;
            io_we = 1'($urandom); io_addr = 16'($urandom); io_wdata = 16'($urandom);
        end
        mem_rdata = 16'($urandom);
    endtask

    initial begin
        int io_acks;
        int exp_io_acks;
        model_reset();
        repeat (2) @(negedge CLK);
        check_outputs();
        Reset = 1'b1;

        // CPU read: strobes in cycle 1, ack/data in cycle 2
        mem_rdata = 16'hBEEF;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040; cpu_wdata = 16'h0000;
        #1 check_eq("stall_c0", 16'(cpu_stall), 16'd1);
        run_cycle();
        check_eq("rd_mem_re", 16'(mem_re), 16'd1);
        check_eq("rd_mem_addr", mem_addr, 16'h0040);
        check_eq("stall_c1", 16'(cpu_stall), 16'd1);
        run_cycle();
        check_eq("rd_ack", 16'(cpu_ack), 16'd1);
        check_eq("rd_data", cpu_rdata, 16'hBEEF);
        cpu_req = 0;
        run_cycle();

        // I/O write
        io_req = 1; io_we = 1; io_addr = 16'h0100; io_wdata = 16'h1234; mem_rdata = 16'h5555;
        run_cycle();
        check_eq("wr_mem_we", 16'(mem_we), 16'd1);
        check_eq("wr_mem_addr", mem_addr, 16'h0100);
        check_eq("wr_mem_wdata", mem_wdata, 16'h1234);
        run_cycle();
        check_eq("wr_io_ack", 16'(io_ack), 16'd1);
        check_eq("wr_cpu_rdata", cpu_rdata, 16'hBEEF);
        io_req = 0;
        run_cycle();
        check_eq("wr_io_ack_end", 16'(io_ack), 16'd0);

        // Simultaneous requests: CPU first, then I/O back-to-back
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0011;
        io_req = 1; io_we = 0; io_addr = 16'h0022; mem_rdata = 16'hA5A5;
        run_cycle();
        check_eq("both_first_addr", mem_addr, 16'h0011);
        run_cycle();
        check_eq("both_cpu_ack", 16'(cpu_ack), 16'd1);
        cpu_req = 0; mem_rdata = 16'h5A5A;
        run_cycle();
        check_eq("both_io_access", 16'(arb_state), 16'd1);
        check_eq("both_io_addr", mem_addr, 16'h0022);
        run_cycle();
        check_eq("both_io_ack", 16'(io_ack), 16'd1);
        check_eq("both_io_rdata", io_rdata, 16'h5A5A);
        io_req = 0;
        run_cycle();

        // Reset in the middle of an access
        io_req = 1; io_we = 1; io_addr = 16'h0200; io_wdata = 16'hCAFE;
        run_cycle();
        #2 Reset = 1'b0;
        #1;
        check_eq("rst_mem_we", 16'(mem_we), 16'd0);
        check_eq("rst_mem_re", 16'(mem_re), 16'd0);
        check_eq("rst_state", 16'(arb_state), 16'd0);
        check_eq("rst_io_ack", 16'(io_ack), 16'd0);
        check_eq("rst_mem_addr", mem_addr, 16'h0000);
        io_req = 0;
        model_reset();
        @(negedge CLK);
        check_outputs();
        Reset = 1'b1;

        // Both requests held continuously for 32 cycles
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0300;
        io_req = 1; io_we = 0; io_addr = 16'h0400;
        io_acks = 0;
        for (int i = 0; i < 32; i++) begin
            mem_rdata = 16'($urandom);
            run_cycle();
            if (io_ack) io_acks++;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_io_acks = 2;
`else
        exp_io_acks = 0;
`endif
        check_eq("io_grants_32", 16'(io_acks), 16'(exp_io_acks));
        cpu_req = 0; io_req = 0;
        run_cycle();
        run_cycle();
        cpu_busy = 0; io_busy = 0;

        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
